// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network datapath cells.
//   act_mode_e : runtime activation selector carried on the 2-bit mode port
//   valid_bit  : position of the valid flag on a result bus of a given payload width
package nn_pkg;

  typedef enum logic [1:0] {
    ACT_IDENTITY = 2'd0,
    ACT_RELU     = 2'd1,
    ACT_LEAKY    = 2'd2,
    ACT_CLAMP    = 2'd3
  } act_mode_e;

  // Result buses carry the signed payload in [w-1:0] and the valid flag directly above it.
  function automatic int unsigned valid_bit(input int unsigned payload_w);
    return payload_w;
  endfunction

endpackage

// File: rtl/requant_sat.sv
// Combinational requantiser: round-half-up, arithmetic right shift, saturate.
//   din  : signed value, IN_W bits
//   dout : signed result clipped to the OUT_W range
//   ovf  : high when the shifted value fell outside the OUT_W range
module requant_sat #(
  parameter int IN_W  = 33,
  parameter int OUT_W = 32,
  parameter int SHIFT = 0
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    ovf
);

  // One guard bit so the rounding add can never wrap.
  localparam int WIDE = IN_W + 1;
  localparam int CW   = ((WIDE > OUT_W) ? WIDE : OUT_W) + 1;
  localparam int RS   = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic signed [WIDE-1:0] RND  = (SHIFT > 0) ? (WIDE'(1) << RS) : '0;
  localparam logic signed [CW-1:0]   MAXV = {{(CW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [CW-1:0]   MINV = {{(CW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [WIDE-1:0] rounded;
  logic signed [WIDE-1:0] shifted;
  logic signed [CW-1:0]   wide_v;

  always_comb begin
    rounded = {din[IN_W-1], din} + RND;
    shifted = rounded >>> SHIFT;
    wide_v  = {{(CW-WIDE){shifted[WIDE-1]}}, shifted};
    ovf     = 1'b0;
    dout    = wide_v[OUT_W-1:0];
    if (wide_v > MAXV) begin
      ovf  = 1'b1;
      dout = MAXV[OUT_W-1:0];
    end else if (wide_v < MINV) begin
      ovf  = 1'b1;
      dout = MINV[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/act_requant_cell.sv
// Layer activation cell: bias add, selectable activation, requantisation,
// index/last regeneration, frame counting and sticky saturation flag.
//   clk, rst       : rising-edge clock, synchronous active-high reset
//   mode           : activation select, latched on the index-0 beat of each frame
//   input_result   : {valid, signed accumulated value}
//   output_index   : neuron index of the emitted beat (zero-extended)
//   output_value   : signed requantised activation
//   output_enable  : output beat valid
//   output_last    : beat carries index NEURON_AMOUNT-1
//   sat_flag       : sticky, set by any saturated beat
//   frame_count    : completed frames, wraps at 2^16
module act_requant_cell
  import nn_pkg::*;
#(
  parameter int                                IN_WIDTH      = 32,
  parameter int                                OUT_WIDTH     = 32,
  parameter int                                NEURON_AMOUNT = 4,
  parameter logic [IN_WIDTH*NEURON_AMOUNT-1:0] BIASES        = '0,
  parameter int                                SHIFT         = 0,
  parameter int                                LEAK_SHIFT    = 3,
  parameter int                                CLAMP_MAX     = 127
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  mode,
  input  logic [IN_WIDTH:0]           input_result,
  output logic [OUT_WIDTH-1:0]        output_index,
  output logic signed [OUT_WIDTH-1:0] output_value,
  output logic                        output_enable,
  output logic                        output_last,
  output logic                        sat_flag,
  output logic [15:0]                 frame_count
);

  localparam int                       IDX_W    = $clog2(NEURON_AMOUNT);
  localparam int unsigned              VB       = valid_bit(IN_WIDTH);
  localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(NEURON_AMOUNT - 1);
  localparam logic signed [IN_WIDTH:0] CLAMP_V  = (IN_WIDTH+1)'(CLAMP_MAX);

  logic                       in_valid;
  logic signed [IN_WIDTH-1:0] in_value;

  assign in_valid = input_result[VB];
  assign in_value = input_result[IN_WIDTH-1:0];

  logic signed [IN_WIDTH-1:0] bias_tab [NEURON_AMOUNT];

  always_comb begin
    for (int unsigned i = 0; i < NEURON_AMOUNT; i++) begin
      bias_tab[i] = BIASES[IN_WIDTH*i +: IN_WIDTH];
    end
  end

  // Frame sequencing
  logic [IDX_W-1:0] idx_q, idx_d;
  act_mode_e        mode_q, mode_d;
  act_mode_e        beat_mode;

  // The index-0 beat uses the port value directly so the frame's first
  // neuron already sees the mode being latched for that frame.
  always_comb begin
    beat_mode = (idx_q == '0) ? act_mode_e'(mode) : mode_q;
    idx_d     = idx_q;
    mode_d    = mode_q;
    if (in_valid) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      if (idx_q == '0) begin
        mode_d = act_mode_e'(mode);
      end
    end
  end

  // Stage 1: bias add and activation
  logic signed [IN_WIDTH:0] sum;
  logic signed [IN_WIDTH:0] act;

  always_comb begin
    sum = {in_value[IN_WIDTH-1], in_value} + {bias_tab[idx_q][IN_WIDTH-1], bias_tab[idx_q]};
    act = sum;
    unique case (beat_mode)
      ACT_IDENTITY: act = sum;
      ACT_RELU:     act = sum[IN_WIDTH] ? '0 : sum;
      ACT_LEAKY:    act = sum[IN_WIDTH] ? (sum >>> LEAK_SHIFT) : sum;
      ACT_CLAMP: begin
        if (sum[IN_WIDTH]) begin
          act = '0;
        end else if (sum > CLAMP_V) begin
          act = CLAMP_V;
        end else begin
          act = sum;
        end
      end
      default:      act = sum;
    endcase
  end

  logic                     s1_valid_q;
  logic [IDX_W-1:0]         s1_idx_q;
  logic                     s1_last_q;
  logic signed [IN_WIDTH:0] s1_act_q;

  // Stage 2: requantisation
  logic signed [OUT_WIDTH-1:0] rq_value;
  logic                        rq_ovf;

  requant_sat #(
    .IN_W  (IN_WIDTH + 1),
    .OUT_W (OUT_WIDTH),
    .SHIFT (SHIFT)
  ) u_requant_sat (
    .din  (s1_act_q),
    .dout (rq_value),
    .ovf  (rq_ovf)
  );

  logic [OUT_WIDTH-1:0]        out_idx_q;
  logic signed [OUT_WIDTH-1:0] out_val_q;
  logic                        out_en_q;
  logic                        out_last_q;
  logic                        sat_q;
  logic [15:0]                 fc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q      <= '0;
      mode_q     <= ACT_RELU;
      s1_valid_q <= 1'b0;
      s1_idx_q   <= '0;
      s1_last_q  <= 1'b0;
      s1_act_q   <= '0;
      out_idx_q  <= '0;
      out_val_q  <= '0;
      out_en_q   <= 1'b0;
      out_last_q <= 1'b0;
      sat_q      <= 1'b0;
      fc_q       <= '0;
    end else begin
      idx_q      <= idx_d;
      mode_q     <= mode_d;
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_idx_q  <= idx_q;
        s1_last_q <= (idx_q == LAST_IDX);
        s1_act_q  <= act;
      end
      out_en_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_idx_q  <= OUT_WIDTH'(s1_idx_q);
        out_val_q  <= rq_value;
        out_last_q <= s1_last_q;
        sat_q      <= sat_q | rq_ovf;
        if (s1_last_q) begin
          fc_q <= fc_q + 16'd1;
        end
      end
    end
  end

  assign output_index  = out_idx_q;
  assign output_value  = out_val_q;
  assign output_enable = out_en_q;
  assign output_last   = out_last_q;
  assign sat_flag      = sat_q;
  assign frame_count   = fc_q;

endmodule

// File: tb/tb_act_requant_cell.sv
module tb_act_requant_cell;
  import nn_pkg::*;

  localparam int IW = 32;
  localparam int OW = 8;
  localparam int NA = 4;
  localparam int SH = 2;
  localparam int LS = 3;
  localparam int CM = 127;
  localparam logic [IW*NA-1:0] BIAS_P = {32'd100, 32'd0, 32'hFFFF_FFEC, 32'd5};

  logic                 clk = 1'b0;
  logic                 rst;
  logic [1:0]           mode;
  logic [IW:0]          input_result;
  logic [OW-1:0]        output_index;
  logic signed [OW-1:0] output_value;
  logic                 output_enable;
  logic                 output_last;
  logic                 sat_flag;
  logic [15:0]          frame_count;

  act_requant_cell #(
    .IN_WIDTH      (IW),
    .OUT_WIDTH     (OW),
    .NEURON_AMOUNT (NA),
    .BIASES        (BIAS_P),
    .SHIFT         (SH),
    .LEAK_SHIFT    (LS),
    .CLAMP_MAX     (CM)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mode          (mode),
    .input_result  (input_result),
    .output_index  (output_index),
    .output_value  (output_value),
    .output_enable (output_enable),
    .output_last   (output_last),
    .sat_flag      (sat_flag),
    .frame_count   (frame_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     idx;
    longint val;
    bit     last;
    bit     sat;
    int     fc;
    int     cyc;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state
  longint    bias_m [NA] = '{5, -20, 0, 100};
  int        m_idx  = 0;
  act_mode_e m_mode = ACT_RELU;
  bit        m_sat  = 1'b0;
  int        m_fc   = 0;

  localparam longint OMAX = (64'sd1 <<< (OW - 1)) - 1;
  localparam longint OMIN = -(64'sd1 <<< (OW - 1));

  function automatic longint fdiv(input longint a, input longint d);
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  task automatic check(input string name, input longint got, input longint want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic beat(input bit vld, input longint val, input logic [1:0] md);
    exp_t   e;
    longint s;
    longint a;
    longint r;
    @(posedge clk);
    #1;
    mode         = md;
    input_result = {vld, IW'(val)};
    if (vld) begin
      if (m_idx == 0) m_mode = act_mode_e'(md);
      s = val + bias_m[m_idx];
      case (m_mode)
        ACT_IDENTITY: a = s;
        ACT_RELU:     a = (s < 0) ? 0 : s;
        ACT_LEAKY:    a = (s < 0) ? fdiv(s, 2 ** LS) : s;
        default:      a = (s < 0) ? 0 : ((s > CM) ? CM : s);
      endcase
      r = fdiv(a + ((SH > 0) ? (2 ** (SH - 1)) : 0), 2 ** SH);
      if (r > OMAX) begin
        r = OMAX;
        m_sat = 1'b1;
      end else if (r < OMIN) begin
        r = OMIN;
        m_sat = 1'b1;
      end
      e.idx  = m_idx;
      e.val  = r;
      e.last = (m_idx == NA - 1);
      if (e.last) m_fc = (m_fc + 1) % 65536;
      e.sat  = m_sat;
      e.fc   = m_fc;
      e.cyc  = cyc;
      sbq.push_back(e);
      m_idx = (m_idx + 1) % NA;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, longint'($signed($urandom)), 2'($urandom));
  endtask

  task automatic do_reset(input int ncyc);
    @(posedge clk);
    #1;
    rst          = 1'b1;
    mode         = 2'($urandom);
    input_result = {1'b1, IW'($urandom)};
    // Beats issued in the previous cycle are still in the pipe and get discarded.
    while (sbq.size() > 0 && sbq[$].cyc >= cyc - 1) void'(sbq.pop_back());
    m_idx  = 0;
    m_mode = ACT_RELU;
    m_sat  = 1'b0;
    m_fc   = 0;
    repeat (ncyc - 1) @(posedge clk);
    @(posedge clk);
    #1;
    rst          = 1'b0;
    input_result = {1'b0, IW'($urandom)};
    check("rst_enable", longint'(output_enable), 0);
    check("rst_index", longint'(output_index), 0);
    check("rst_value", longint'(output_value), 0);
    check("rst_last", longint'(output_last), 0);
    check("rst_sat", longint'(sat_flag), 0);
    check("rst_frame_count", longint'(frame_count), 0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (output_enable === 1'b1) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_beat: got index %0d value %0d, want no beat (cycle %0d)",
                 output_index, output_value, cyc);
      end else begin
        e = sbq.pop_front();
        check("index", longint'(output_index), e.idx);
        check("value", longint'(output_value), e.val);
        check("last", longint'(output_last), longint'(e.last));
        check("sat_flag", longint'(sat_flag), longint'(e.sat));
        check("frame_count", longint'(frame_count), e.fc);
        check("latency", cyc, e.cyc + 2);
      end
    end
  end

  initial begin
    rst          = 1'b1;
    mode         = 2'd0;
    input_result = '0;
    do_reset(3);

    // relu frame, consecutive beats
    beat(1, 10, ACT_RELU);
    beat(1, -5, ACT_RELU);
    beat(1, 0, ACT_RELU);
    beat(1, 7, ACT_RELU);
    // leaky frame; mode changes mid-frame are ignored
    beat(1, -16, ACT_LEAKY);
    beat(1, -5, ACT_IDENTITY);
    beat(1, -200, ACT_CLAMP);
    beat(1, -301, ACT_RELU);
    // identity with positive and negative saturation
    beat(1, 1000, ACT_IDENTITY);
    beat(1, -1000, ACT_RELU);
    beat(1, 10, ACT_RELU);
    beat(1, 9, ACT_RELU);
    beat(1, -6, ACT_IDENTITY);
    beat(1, 10, ACT_LEAKY);
    beat(1, -6, ACT_LEAKY);
    beat(1, -1000, ACT_LEAKY);
    // clamp frame
    beat(1, 1, ACT_CLAMP);
    beat(1, 1, ACT_RELU);
    beat(1, 200, ACT_RELU);
    beat(1, 1, ACT_RELU);
    // relu latched, port switches to identity after index 1, gaps between beats
    beat(1, 3, ACT_RELU);    idle(3);
    beat(1, -3, ACT_RELU);   idle(3);
    beat(1, -3, ACT_IDENTITY); idle(3);
    beat(1, -3, ACT_IDENTITY); idle(3);
    beat(1, -3, ACT_IDENTITY);
    beat(1, -3, ACT_IDENTITY);
    beat(1, -3, ACT_IDENTITY);
    beat(1, -3, ACT_IDENTITY);
    // reset mid-frame after two beats
    beat(1, 1000, ACT_IDENTITY);
    beat(1, 50, ACT_IDENTITY);
    beat(1, 60, ACT_IDENTITY);
    do_reset(1);
    beat(1, -7, ACT_IDENTITY);
    beat(1, 8, ACT_RELU);
    idle(2);
    beat(1, 20, ACT_RELU);
    beat(1, 30, ACT_RELU);
    // three back-to-back frames
    for (int i = 0; i < 3 * NA; i++) begin
      beat(1, longint'($urandom_range(0, 4000)) - 2000, 2'($urandom));
    end

    // randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      int     r;
      longint v;
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 9) == 0) v = longint'($signed($urandom));
      else                           v = longint'($urandom_range(0, 4000)) - 2000;
      if (r < 2)       do_reset(1 + $urandom_range(0, 1));
      else if (r < 72) beat(1, v, 2'($urandom));
      else             beat(0, v, 2'($urandom));
    end

    // drain with a bounded wait
    for (int i = 0; i < 10 && sbq.size() > 0; i++) idle(1);
    @(negedge clk);
    #1;
    check("drain_empty", sbq.size(), 0);
    check("final_frame_count", longint'(frame_count), m_fc);
    check("final_sat_flag", longint'(sat_flag), longint'(m_sat));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
